// File: rtl/xor_session_ctrl.sv
// xor_session_ctrl: session sequencer for an XOR encryption datapath.
// Sequences key load, message load, encrypt and serialize. It also tracks which operands
// are valid and reports the error code of the last command.
//
// Ports:
//   clk, rst_n        - rising-edge clock, asynchronous active-low reset
//   ena               - global enable; state, counters and outputs hold while low
//   iCmd_valid, iCmd  - command strobe and code (01 key, 10 msg, 11 encrypt, 00 illegal)
//   iEnc_done         - encryption engine completion pulse
//   iSer_done         - serializer completion pulse
//   oLoad_key         - key deserializer load flag
//   oLoad_msg         - message deserializer load flag
//   oEnc_start        - one-cycle encryption start pulse
//   oSer_start        - one-cycle serializer start pulse
//   oBusy             - high whenever not idle
//   oKey_valid        - key fully loaded
//   oMsg_valid        - message fully loaded and not yet consumed
//   oDone             - one-cycle pulse on successful session end
//   oErr_code         - 00 none, 01 illegal, 10 not ready, 11 timeout
module xor_session_ctrl #(
   parameter int unsigned KEY_BITS = 8,
   parameter int unsigned MSG_BITS = 64,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       iCmd_valid,
   input  logic [1:0] iCmd,
   input  logic       iEnc_done,
   input  logic       iSer_done,
   output logic       oLoad_key,
   output logic       oLoad_msg,
   output logic       oEnc_start,
   output logic       oSer_start,
   output logic       oBusy,
   output logic       oKey_valid,
   output logic       oMsg_valid,
   output logic       oDone,
   output logic [1:0] oErr_code
);

   typedef enum logic [2:0] {StIdle, StLoadKey, StLoadMsg, StEncWait, StSerWait} state_e;

   // Exit compares use the last count value so the load flag is high for exactly N cycles.
   localparam logic [6:0] KeyLast  = 7'(KEY_BITS - 1);
   localparam logic [6:0] MsgLast  = 7'(MSG_BITS - 1);
   localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

   localparam logic [1:0] ErrNone    = 2'b00;
   localparam logic [1:0] ErrIllegal = 2'b01;
   localparam logic [1:0] ErrNotRdy  = 2'b10;
   localparam logic [1:0] ErrTimeout = 2'b11;

   state_e     state_q, state_d;
   logic [6:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       load_key_q, load_key_d;
   logic       load_msg_q, load_msg_d;
   logic       enc_start_q, enc_start_d;
   logic       ser_start_q, ser_start_d;
   logic       busy_q, busy_d;
   logic       key_valid_q, key_valid_d;
   logic       msg_valid_q, msg_valid_d;
   logic       done_q, done_d;
   logic [1:0] err_q, err_d;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      load_key_d  = load_key_q;
      load_msg_d  = load_msg_q;
      enc_start_d = enc_start_q;
      ser_start_d = ser_start_q;
      busy_d      = busy_q;
      key_valid_d = key_valid_q;
      msg_valid_d = msg_valid_q;
      done_d      = done_q;
      err_d       = err_q;

      if (ena) begin
         // Pulses last one enabled cycle.
         enc_start_d = 1'b0;
         ser_start_d = 1'b0;
         done_d      = 1'b0;

         unique case (state_q)
            StIdle: begin
               if (iCmd_valid) begin
                  unique case (iCmd)
                     2'b01: begin
                        state_d     = StLoadKey;
                        bit_cnt_d   = '0;
                        key_valid_d = 1'b0;
                        load_key_d  = 1'b1;
                        err_d       = ErrNone;
                     end
                     2'b10: begin
                        state_d     = StLoadMsg;
                        bit_cnt_d   = '0;
                        msg_valid_d = 1'b0;
                        load_msg_d  = 1'b1;
                        err_d       = ErrNone;
                     end
                     2'b11: begin
                        if (key_valid_q && msg_valid_q) begin
                           state_d     = StEncWait;
                           wait_cnt_d  = '0;
                           enc_start_d = 1'b1;
                           err_d       = ErrNone;
                        end else begin
                           err_d = ErrNotRdy;
                        end
                     end
                     default: err_d = ErrIllegal;
                  endcase
               end
            end
            StLoadKey: begin
               if (bit_cnt_q == KeyLast) begin
                  state_d     = StIdle;
                  load_key_d  = 1'b0;
                  key_valid_d = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 7'd1;
               end
            end
            StLoadMsg: begin
               if (bit_cnt_q == MsgLast) begin
                  state_d     = StIdle;
                  load_msg_d  = 1'b0;
                  msg_valid_d = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 7'd1;
               end
            end
            StEncWait: begin
               // Done has priority over the timeout on the same cycle.
               if (iEnc_done) begin
                  state_d     = StSerWait;
                  wait_cnt_d  = '0;
                  ser_start_d = 1'b1;
               end else if (wait_cnt_q == WaitLast) begin
                  state_d     = StIdle;
                  err_d       = ErrTimeout;
                  msg_valid_d = 1'b0;
               end else begin
                  wait_cnt_d = wait_cnt_q + 8'd1;
               end
            end
            StSerWait: begin
               if (iSer_done) begin
                  state_d     = StIdle;
                  done_d      = 1'b1;
                  msg_valid_d = 1'b0;
               end else if (wait_cnt_q == WaitLast) begin
                  state_d     = StIdle;
                  err_d       = ErrTimeout;
                  msg_valid_d = 1'b0;
               end else begin
                  wait_cnt_d = wait_cnt_q + 8'd1;
               end
            end
            default: state_d = StIdle;
         endcase

         busy_d = (state_d != StIdle);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         wait_cnt_q  <= '0;
         load_key_q  <= 1'b0;
         load_msg_q  <= 1'b0;
         enc_start_q <= 1'b0;
         ser_start_q <= 1'b0;
         busy_q      <= 1'b0;
         key_valid_q <= 1'b0;
         msg_valid_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= ErrNone;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         load_key_q  <= load_key_d;
         load_msg_q  <= load_msg_d;
         enc_start_q <= enc_start_d;
         ser_start_q <= ser_start_d;
         busy_q      <= busy_d;
         key_valid_q <= key_valid_d;
         msg_valid_q <= msg_valid_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign oLoad_key  = load_key_q;
   assign oLoad_msg  = load_msg_q;
   assign oEnc_start = enc_start_q;
   assign oSer_start = ser_start_q;
   assign oBusy      = busy_q;
   assign oKey_valid = key_valid_q;
   assign oMsg_valid = msg_valid_q;
   assign oDone      = done_q;
   assign oErr_code  = err_q;

endmodule

// File: tb/tb_xor_session_ctrl.sv
// Bench for xor_session_ctrl: directed scenarios plus a randomized command stream checked
// against a transaction-level model of the key/message valid flags and the error code.
module tb_xor_session_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       iCmd_valid = 1'b0;
   logic [1:0] iCmd = 2'b00;
   logic       iEnc_done = 1'b0;
   logic       iSer_done = 1'b0;
   logic       oLoad_key, oLoad_msg, oEnc_start, oSer_start, oBusy;
   logic       oKey_valid, oMsg_valid, oDone;
   logic [1:0] oErr_code;

   int checks = 0;
   int failures = 0;

   // Model state: what the flags should be after each completed transaction.
   logic       m_key, m_msg;
   logic [1:0] m_err;

   xor_session_ctrl #(.KEY_BITS(8), .MSG_BITS(64), .TIMEOUT(255)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .iCmd_valid(iCmd_valid), .iCmd(iCmd),
      .iEnc_done(iEnc_done), .iSer_done(iSer_done), .oLoad_key(oLoad_key),
      .oLoad_msg(oLoad_msg), .oEnc_start(oEnc_start), .oSer_start(oSer_start),
      .oBusy(oBusy), .oKey_valid(oKey_valid), .oMsg_valid(oMsg_valid), .oDone(oDone),
      .oErr_code(oErr_code)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [9:0] all_outs();
      return {oLoad_key, oLoad_msg, oEnc_start, oSer_start, oBusy, oKey_valid, oMsg_valid,
              oDone, oErr_code};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] c);
      iCmd = c;
      iCmd_valid = 1'b1;
      step();
      iCmd_valid = 1'b0;
      iCmd = 2'($urandom);
   endtask

   // Counts enabled edges while the load flag is high; optional random ena and stray inputs.
   task automatic run_load(input bit is_key, input bit rnd, output int n);
      int g;
      n = 0;
      g = 0;
      while (((is_key && oLoad_key) || (!is_key && oLoad_msg)) && g < 1000) begin
         ena = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         iCmd_valid = rnd ? ($urandom_range(0, 4) == 0) : 1'b0;
         iCmd = 2'($urandom);
         iEnc_done = rnd ? ($urandom_range(0, 4) == 0) : 1'b0;
         iSer_done = rnd ? ($urandom_range(0, 4) == 0) : 1'b0;
         if (ena) n++;
         step();
         g++;
      end
      ena = 1'b1;
      iCmd_valid = 1'b0;
      iEnc_done = 1'b0;
      iSer_done = 1'b0;
   endtask

   // Drives done pulses enc_at cycles after acceptance and ser_dly cycles after the serializer
   // start (negative = never). Returns pulse counts and the cycle index where it stopped.
   task automatic run_session(input int enc_at, input int ser_dly, input bit stray,
                              output int enc_n, output int ser_n, output int done_n,
                              output int t);
      int ser_at;
      bit ser_seen;
      enc_n = 0;
      ser_n = 0;
      done_n = 0;
      t = 0;
      ser_at = 1 << 30;
      ser_seen = 1'b0;
      while (t < 700) begin
         if (oEnc_start) enc_n++;
         if (oSer_start) begin
            ser_n++;
            if (!ser_seen) begin
               ser_seen = 1'b1;
               if (ser_dly >= 0) ser_at = t + ser_dly;
            end
         end
         if (oDone) begin
            done_n++;
            break;
         end
         if (!oBusy) break;
         iEnc_done = (t == enc_at);
         iSer_done = ser_seen && (t == ser_at);
         if (stray && !ser_seen && $urandom_range(0, 2) == 0) iSer_done = 1'b1;
         if (stray && ser_seen && $urandom_range(0, 2) == 0) iEnc_done = 1'b1;
         iCmd_valid = stray && ($urandom_range(0, 3) == 0);
         iCmd = 2'($urandom);
         step();
         t++;
      end
      iEnc_done = 1'b0;
      iSer_done = 1'b0;
      iCmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      rst_n = 1'b0;
      ena = 1'b1;
      #3;
      checks++;
      if (all_outs() !== 10'h0) begin
         failures++;
         $display("FAIL reset_outs: got %b expected %b", all_outs(), 10'h0);
      end
      iCmd_valid = 1'b1;
      iCmd = 2'b01;
      step();
      step();
      iCmd_valid = 1'b0;
      checks++;
      if (all_outs() !== 10'h0) begin
         failures++;
         $display("FAIL reset_hold: got %b expected %b", all_outs(), 10'h0);
      end
      rst_n = 1'b1;
      issue(2'b01);
      checks++;
      if ({oLoad_key, oBusy} !== 2'b11) begin
         failures++;
         $display("FAIL first_cmd_accept: got %b expected %b", {oLoad_key, oBusy}, 2'b11);
      end
      run_load(1'b1, 1'b0, n);
      checks++;
      if (n !== 8) begin
         failures++;
         $display("FAIL first_key_len: got %0d expected %0d", n, 8);
      end
   endtask

   task automatic test_key_load();
      int n;
      issue(2'b01);
      checks++;
      if ({oLoad_key, oBusy, oKey_valid} !== 3'b110) begin
         failures++;
         $display("FAIL key_start: got %b expected %b", {oLoad_key, oBusy, oKey_valid}, 3'b110);
      end
      run_load(1'b1, 1'b1, n);
      checks++;
      if (n !== 8) begin
         failures++;
         $display("FAIL key_len: got %0d expected %0d", n, 8);
      end
      checks++;
      if ({oKey_valid, oBusy, oLoad_key} !== 3'b100) begin
         failures++;
         $display("FAIL key_end: got %b expected %b", {oKey_valid, oBusy, oLoad_key}, 3'b100);
      end
   endtask

   task automatic test_msg_ena_gating();
      int n;
      int g;
      issue(2'b10);
      n = 0;
      g = 0;
      while (oLoad_msg && g < 500) begin
         ena = !(g >= 20 && g < 30);
         if (ena) n++;
         step();
         if (!ena) begin
            checks++;
            if ({oLoad_msg, oBusy, oMsg_valid} !== 3'b110) begin
               failures++;
               $display("FAIL ena_hold: got %b expected %b", {oLoad_msg, oBusy, oMsg_valid},
                        3'b110);
            end
         end
         g++;
      end
      ena = 1'b1;
      checks++;
      if (n !== 64) begin
         failures++;
         $display("FAIL msg_len_gated: got %0d expected %0d", n, 64);
      end
      checks++;
      if ({oMsg_valid, oBusy} !== 2'b10) begin
         failures++;
         $display("FAIL msg_end: got %b expected %b", {oMsg_valid, oBusy}, 2'b10);
      end
   endtask

   task automatic test_full_session();
      int e, s, d, t;
      issue(2'b11);
      checks++;
      if ({oEnc_start, oBusy, oErr_code} !== 4'b1100) begin
         failures++;
         $display("FAIL enc_accept: got %b expected %b", {oEnc_start, oBusy, oErr_code},
                  4'b1100);
      end
      run_session(5, 70, 1'b0, e, s, d, t);
      checks++;
      if ({e, s, d} !== {32'd1, 32'd1, 32'd1}) begin
         failures++;
         $display("FAIL session_pulses: got enc=%0d ser=%0d done=%0d expected 1 1 1", e, s, d);
      end
      checks++;
      if ({oMsg_valid, oKey_valid, oErr_code, oBusy} !== 5'b01000) begin
         failures++;
         $display("FAIL session_flags: got %b expected %b",
                  {oMsg_valid, oKey_valid, oErr_code, oBusy}, 5'b01000);
      end
      step();
      checks++;
      if (oDone !== 1'b0) begin
         failures++;
         $display("FAIL done_one_cycle: got %b expected %b", oDone, 1'b0);
      end
   endtask

   task automatic test_not_ready();
      issue(2'b11);
      checks++;
      if ({oErr_code, oBusy, oEnc_start} !== 4'b1000) begin
         failures++;
         $display("FAIL not_ready: got %b expected %b", {oErr_code, oBusy, oEnc_start}, 4'b1000);
      end
      repeat (3) step();
      checks++;
      if ({oErr_code, oBusy, oEnc_start} !== 4'b1000) begin
         failures++;
         $display("FAIL not_ready_sticky: got %b expected %b", {oErr_code, oBusy, oEnc_start},
                  4'b1000);
      end
   endtask

   task automatic test_illegal();
      int n;
      issue(2'b00);
      repeat (4) step();
      checks++;
      if ({oErr_code, oBusy} !== 3'b010) begin
         failures++;
         $display("FAIL illegal_sticky: got %b expected %b", {oErr_code, oBusy}, 3'b010);
      end
      issue(2'b01);
      checks++;
      if ({oErr_code, oLoad_key} !== 3'b001) begin
         failures++;
         $display("FAIL err_clear_on_accept: got %b expected %b", {oErr_code, oLoad_key}, 3'b001);
      end
      run_load(1'b1, 1'b0, n);
   endtask

   task automatic test_timeouts();
      int n, e, s, d, t;
      // Encrypt never completes.
      issue(2'b10);
      run_load(1'b0, 1'b0, n);
      issue(2'b11);
      run_session(-1, -1, 1'b0, e, s, d, t);
      checks++;
      if (t !== 255 || e !== 1 || s !== 0 || d !== 0) begin
         failures++;
         $display("FAIL enc_timeout_len: got t=%0d enc=%0d ser=%0d done=%0d expected 255 1 0 0",
                  t, e, s, d);
      end
      checks++;
      if ({oErr_code, oMsg_valid, oKey_valid, oBusy} !== 5'b11010) begin
         failures++;
         $display("FAIL enc_timeout_flags: got %b expected %b",
                  {oErr_code, oMsg_valid, oKey_valid, oBusy}, 5'b11010);
      end
      // Serializer never completes.
      issue(2'b10);
      run_load(1'b0, 1'b0, n);
      issue(2'b11);
      run_session(3, -1, 1'b0, e, s, d, t);
      checks++;
      if (t !== 259 || oErr_code !== 2'b11 || d !== 0) begin
         failures++;
         $display("FAIL ser_timeout: got t=%0d err=%b done=%0d expected 259 11 0",
                  t, oErr_code, d);
      end
      // Done on the last wait cycle of both phases wins over the timeout.
      issue(2'b10);
      run_load(1'b0, 1'b0, n);
      issue(2'b11);
      run_session(254, 254, 1'b0, e, s, d, t);
      checks++;
      if (d !== 1 || oErr_code !== 2'b00 || t !== 510) begin
         failures++;
         $display("FAIL done_at_limit: got done=%0d err=%b t=%0d expected 1 00 510",
                  d, oErr_code, t);
      end
   endtask

   task automatic test_back_to_back();
      int n, e, s, d, t;
      issue(2'b10);
      run_load(1'b0, 1'b0, n);
      issue(2'b11);
      run_session(2, 3, 1'b1, e, s, d, t);
      checks++;
      if (d !== 1) begin
         failures++;
         $display("FAIL b2b_done: got %0d expected %0d", d, 1);
      end
      issue(2'b10);
      checks++;
      if ({oLoad_msg, oDone, oBusy} !== 3'b101) begin
         failures++;
         $display("FAIL b2b_accept: got %b expected %b", {oLoad_msg, oDone, oBusy}, 3'b101);
      end
      run_load(1'b0, 1'b0, n);
   endtask

   task automatic test_reset_mid_load();
      int n;
      issue(2'b10);
      repeat (30) step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (all_outs() !== 10'h0) begin
         failures++;
         $display("FAIL async_reset: got %b expected %b", all_outs(), 10'h0);
      end
      step();
      step();
      rst_n = 1'b1;
      step();
      step();
      checks++;
      if (all_outs() !== 10'h0) begin
         failures++;
         $display("FAIL post_reset_quiet: got %b expected %b", all_outs(), 10'h0);
      end
      issue(2'b10);
      run_load(1'b0, 1'b0, n);
      checks++;
      if (n !== 64 || oMsg_valid !== 1'b1 || oKey_valid !== 1'b0) begin
         failures++;
         $display("FAIL reload_after_reset: got n=%0d mv=%b kv=%b expected 64 1 0",
                  n, oMsg_valid, oKey_valid);
      end
   endtask

   task automatic test_random();
      int n, e, s, d, t, r, kind, enc_at, ser_dly;
      logic [1:0] c;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      m_key = 1'b0;
      m_msg = 1'b0;
      m_err = 2'b00;
      for (int it = 0; it < 40; it++) begin
         // Idle gap with ena low: commands offered here must not be taken.
         repeat ($urandom_range(0, 2)) begin
            ena = 1'b0;
            iCmd_valid = 1'($urandom);
            iCmd = 2'($urandom);
            step();
         end
         ena = 1'b1;
         iCmd_valid = 1'b0;
         r = $urandom_range(0, 9);
         c = (r == 0) ? 2'b00 : (r <= 3) ? 2'b01 : (r <= 6) ? 2'b10 : 2'b11;
         issue(c);
         case (c)
            2'b00: m_err = 2'b01;
            2'b01: begin
               run_load(1'b1, 1'b1, n);
               m_key = 1'b1;
               m_err = 2'b00;
               checks++;
               if (n !== 8) begin
                  failures++;
                  $display("FAIL rnd_key_len: got %0d expected %0d", n, 8);
               end
            end
            2'b10: begin
               run_load(1'b0, 1'b1, n);
               m_msg = 1'b1;
               m_err = 2'b00;
               checks++;
               if (n !== 64) begin
                  failures++;
                  $display("FAIL rnd_msg_len: got %0d expected %0d", n, 64);
               end
            end
            default: begin
               if (m_key && m_msg) begin
                  kind = $urandom_range(0, 9);
                  enc_at = (kind == 8) ? -1 : int'($urandom_range(0, 40));
                  ser_dly = (kind == 9) ? -1 : int'($urandom_range(0, 40));
                  run_session(enc_at, ser_dly, 1'b1, e, s, d, t);
                  m_msg = 1'b0;
                  m_err = (kind >= 8) ? 2'b11 : 2'b00;
                  checks++;
                  if (d !== ((kind < 8) ? 1 : 0) || e !== 1) begin
                     failures++;
                     $display("FAIL rnd_session: got done=%0d enc=%0d expected done=%0d enc=1",
                              d, e, (kind < 8) ? 1 : 0);
                  end
               end else begin
                  m_err = 2'b10;
                  checks++;
                  if (oEnc_start !== 1'b0) begin
                     failures++;
                     $display("FAIL rnd_no_start: got %b expected %b", oEnc_start, 1'b0);
                  end
               end
            end
         endcase
         checks++;
         if ({oBusy, oKey_valid, oMsg_valid, oErr_code} !== {1'b0, m_key, m_msg, m_err}) begin
            failures++;
            $display("FAIL rnd_flags it=%0d cmd=%b: got %b expected %b", it, c,
                     {oBusy, oKey_valid, oMsg_valid, oErr_code}, {1'b0, m_key, m_msg, m_err});
         end
      end
   endtask

   initial begin
      test_reset();
      test_key_load();
      test_msg_ena_gating();
      test_full_session();
      test_not_ready();
      test_illegal();
      test_timeouts();
      test_back_to_back();
      test_reset_mid_load();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
